// File: rtl/nearest_upsampler.sv
// Nearest-neighbour upsampler: buffers one pooled input row, then replays each
// pixel SCALE times horizontally and the whole row SCALE times vertically.
module nearest_upsampler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_COLS    = 4,
  parameter int unsigned IN_ROWS    = 4,
  parameter int unsigned SCALE      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  frame_done
);

  localparam int unsigned COL_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int unsigned ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_ROWS - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t                  state, n_state;
  logic [COL_W-1:0]        wcol, n_wcol;
  logic [COL_W-1:0]        icol, n_icol;
  logic [SUB_W-1:0]        sub, n_sub;
  logic [SUB_W-1:0]        rep, n_rep;
  logic [ROW_W-1:0]        irow, n_irow;
  logic                    n_done;
  logic                    in_fire, out_fire;
  logic [DATA_WIDTH-1:0]   line_buf [IN_COLS];

  assign in_fire   = (state == FILL) && in_valid && in_ready;
  assign out_fire  = (state == EMIT) && out_valid && out_ready;
  assign out_pixel = line_buf[icol];

  always_comb begin
    n_state = state;
    n_wcol  = wcol;
    n_icol  = icol;
    n_sub   = sub;
    n_rep   = rep;
    n_irow  = irow;
    n_done  = 1'b0;
    if (in_fire) begin
      if (wcol == COL_LAST) begin
        n_wcol  = '0;
        n_state = EMIT;
      end else begin
        n_wcol = wcol + 1'b1;
      end
    end
    if (out_fire) begin
      if (sub != SUB_LAST) begin
        n_sub = sub + 1'b1;
      end else begin
        n_sub = '0;
        if (icol != COL_LAST) begin
          n_icol = icol + 1'b1;
        end else begin
          n_icol = '0;
          if (rep != SUB_LAST) begin
            n_rep = rep + 1'b1;
          end else begin
            n_rep   = '0;
            n_state = FILL;
            n_done  = (irow == ROW_LAST);
            n_irow  = (irow == ROW_LAST) ? '0 : irow + 1'b1;
          end
        end
      end
    end
  end

  // Handshake and framing flags are registered from the next-state values so
  // they line up with the counters they qualify and hold during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wcol       <= '0;
      icol       <= '0;
      sub        <= '0;
      rep        <= '0;
      irow       <= '0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      for (int unsigned i = 0; i < IN_COLS; i++) line_buf[i] <= '0;
    end else begin
      state      <= n_state;
      wcol       <= n_wcol;
      icol       <= n_icol;
      sub        <= n_sub;
      rep        <= n_rep;
      irow       <= n_irow;
      frame_done <= n_done;
      in_ready   <= (n_state == FILL);
      out_valid  <= (n_state == EMIT);
      out_sof    <= (n_state == EMIT) && (n_irow == '0) && (n_rep == '0) &&
                    (n_icol == '0) && (n_sub == '0);
      out_eol    <= (n_state == EMIT) && (n_icol == COL_LAST) && (n_sub == SUB_LAST);
      if (in_fire) line_buf[wcol] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_nearest_upsampler.sv
// Directed bench for nearest_upsampler at 4x4 input, scale 2.
module tb_nearest_upsampler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  nearest_upsampler #(
    .DATA_WIDTH(8),
    .IN_COLS(4),
    .IN_ROWS(4),
    .SCALE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_pixel(in_pixel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_pixel(out_pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All drives and samples happen on the falling edge.
  task automatic push(input logic [7:0] p);
    int t = 0;
    in_pixel = p;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pull(input string tag, input logic [7:0] px, input logic sof, input logic eol);
    int t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_px"}, out_pixel, px);
    check({tag, "_sof"}, out_sof, sof);
    check({tag, "_eol"}, out_eol, eol);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] row [4];
    logic [7:0] seq [7];
    logic       vld [7];
    logic [7:0] kept [4];

    rst = 1'b1; in_pixel = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sof", out_sof, 0);
    check("rst_eol", out_eol, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pixel", out_pixel, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Single row 1,2,3,4 -> 1,1,2,2,3,3,4,4 twice
    row = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 4; i++) push(row[i]);
    check("row_out_valid_lat", out_valid, 1);
    check("row_in_ready_emit", in_ready, 0);
    for (int i = 0; i < 16; i++)
      pull("row", row[(i % 8) / 2], i == 0, (i % 8) == 7);
    check("row_back_fill", in_ready, 1);
    check("row_no_done", frame_done, 0);

    // Full frame 1..16
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) push(8'(r * 4 + c + 1));
      for (int i = 0; i < 16; i++)
        pull("frame", 8'(r * 4 + (i % 8) / 2 + 1), (r == 0) && (i == 0), (i % 8) == 7);
    end
    check("frame_done_pulse", frame_done, 1);
    @(negedge clk);
    check("frame_done_single", frame_done, 0);
    row = '{8'd5, 8'd6, 8'd7, 8'd8};
    for (int i = 0; i < 4; i++) push(row[i]);
    pull("next_frame", 8'd5, 1'b1, 1'b0);

    // Stall at output index 5
    do_reset();
    row = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 4; i++) push(row[i]);
    for (int i = 0; i < 5; i++) pull("pre_stall", row[i / 2], i == 0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_px", out_pixel, 8'd3);
      check("stall_valid", out_valid, 1);
      check("stall_eol", out_eol, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    pull("resume", 8'd3, 1'b0, 1'b0);
    pull("resume", 8'd4, 1'b0, 1'b0);
    pull("resume", 8'd4, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) pull("rep2", row[i / 2], 1'b0, i == 7);

    // Gapped input beats, in_valid held high during emit
    seq  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    vld  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    kept = '{8'd10, 8'd13, 8'd14, 8'd16};
    for (int i = 0; i < 7; i++) begin
      check("gap_in_ready", in_ready, 1);
      in_pixel = seq[i];
      in_valid = vld[i];
      @(negedge clk);
    end
    check("gap_out_valid", out_valid, 1);
    in_pixel = 8'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("emit_in_ready", in_ready, 0);
      pull("gap", kept[(i % 8) / 2], 1'b0, (i % 8) == 7);
    end
    in_valid = 1'b0;

    // Reset at output index 10
    row = '{8'd20, 8'd21, 8'd22, 8'd23};
    for (int i = 0; i < 4; i++) push(row[i]);
    for (int i = 0; i < 10; i++) pull("pre_rst", row[(i % 8) / 2], 1'b0, (i % 8) == 7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid2", out_valid, 0);
    for (int i = 0; i < 4; i++) push(8'd9);
    for (int i = 0; i < 16; i++) pull("nines", 8'd9, i == 0, (i % 8) == 7);

    // Extreme values
    row = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) push(row[i]);
    for (int i = 0; i < 16; i++) pull("extreme", row[(i % 8) / 2], 1'b0, (i % 8) == 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nearest_upsampler.md
NEAREST_UPSAMPLER -- requirements
Module: nearest_upsampler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IN_COLS, default 4, pixels per input (pooled) row.
REQ-003 SHALL have parameter IN_ROWS, default 4, rows per input frame.
REQ-004 SHALL have parameter SCALE, default 2, replication factor in both dimensions (>=1).
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port in_pixel, input, DATA_WIDTH, pooled pixel, raster order.
REQ-008 SHALL have port in_valid, input, 1, in_pixel valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts in_pixel this cycle.
REQ-010 SHALL have port out_pixel, output, DATA_WIDTH, upsampled pixel, raster order.
REQ-011 SHALL have port out_valid, output, 1, out_pixel valid.
REQ-012 SHALL have port out_ready, input, 1, sink accepts out_pixel this cycle.
REQ-013 SHALL have port out_sof, output, 1, qualifies first pixel of output frame.
REQ-014 SHALL have port out_eol, output, 1, qualifies last pixel of each output row.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse after final output pixel of frame.

Function
REQ-016 SHALL implement a two-state FSM: FILL (load one input row) and EMIT (output SCALE rows).
REQ-017 SHALL store one input row in a line buffer of IN_COLS x DATA_WIDTH.
REQ-018 SHALL define input transfer as in_valid && in_ready and output transfer as out_valid && out_ready.
REQ-019 SHALL drive in_ready=1 exactly in FILL and 0 in EMIT; out_valid=1 exactly in EMIT.
REQ-020 SHALL, per input transfer in FILL, write in_pixel to buf[wcol] and increment wcol; cycles with in_valid=0 write nothing.
REQ-021 SHALL, on the transfer with wcol==IN_COLS-1, reset wcol to 0 and enter EMIT next cycle (first out_valid one cycle after last input accepted).
REQ-022 SHALL present out_pixel = buf[icol], using counters icol (0..IN_COLS-1), sub (0..SCALE-1), rep (0..SCALE-1); no divider.
REQ-023 SHALL, per output transfer, increment sub; at sub==SCALE-1 wrap sub to 0 and increment icol.
REQ-024 SHALL, on output transfer with icol==IN_COLS-1 and sub==SCALE-1 (end of output row): if rep<SCALE-1, increment rep and restart icol=0; else rep=0, increment irow, return to FILL.
REQ-025 SHALL wrap irow from IN_ROWS-1 to 0 at end of frame.
REQ-026 SHALL assert out_sof when EMIT && irow==0 && rep==0 && icol==0 && sub==0.
REQ-027 SHALL assert out_eol when EMIT && icol==IN_COLS-1 && sub==SCALE-1.
REQ-028 SHALL register frame_done high for one cycle, the cycle after final output transfer of irow==IN_ROWS-1, rep==SCALE-1.
REQ-029 SHALL hold out_pixel, out_sof, out_eol and all counters stable while out_valid && !out_ready (no skip, no duplicate).
REQ-030 SHALL pass pixel values unmodified; no arithmetic on data, all counters sized by $clog2 of range (min 1 bit).
REQ-031 SHALL ignore in_pixel/in_valid during EMIT (nothing written, nothing lost since in_ready=0).

Reset
REQ-032 SHALL, while rst high, force state FILL, wcol/icol/sub/rep/irow=0, frame_done=0, out_valid=0, in_ready=0, out_sof=0, out_eol=0, line buffer cleared to 0.
REQ-033 SHALL, in the first cycle after rst deasserts, drive in_ready=1, out_valid=0.
REQ-034 SHALL, on reset mid-FILL or mid-EMIT, discard partial row and position; next frame starts with out_sof on its first output pixel.

Verification (IN_COLS=4, IN_ROWS=4, SCALE=2)
REQ-035 SHALL cover: row 1,2,3,4, out_ready=1 -> out 1,1,2,2,3,3,4,4 twice; out_valid one cycle after 4th accept; out_sof on 1st; out_eol on 8th and 16th.
REQ-036 SHALL cover: frame 1..16 streamed -> 64 outputs in raster order, frame_done single pulse one cycle after 64th transfer, next frame's first pixel carries out_sof.
REQ-037 SHALL cover: out_ready low 3 cycles at output index 5 -> out_pixel=3 held stable, sequence resumes 3,4,4 with no loss/duplication.
REQ-038 SHALL cover: in_valid toggled 1,0,0,1,1,0,1 in FILL -> only 4 valid beats stored; in_ready=0 throughout EMIT while in_valid=1.
REQ-039 SHALL cover: rst pulsed at output index 10 -> out_valid=0 cycle after, in_ready=1 after release, fresh row 9,9,9,9 yields out_sof on first 9.
REQ-040 SHALL cover: in_pixel 8'hFF and 8'h00 -> output identical values, no width truncation.
